// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x instruction-side memory bridge.
// A fetch response is the data word plus a bus-error flag.
package cv32e40x_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_inst_resp_t;

    // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial:
    // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
    localparam logic [15:0] INSTR_LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/cv32e40x_instr_mem_resp_fifo.sv
// In-order response FIFO for the instruction memory bridge.
// The head is registered, so a push into an empty FIFO shows up one cycle later.
module cv32e40x_instr_mem_resp_fifo
    import cv32e40x_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter type         elem_t = obi_inst_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push,
    input  elem_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output elem_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    elem_t            mem_q [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/cv32e40x_instr_obi_mem.sv
// Instruction-side OBI bridge onto a synchronous single-port SRAM with bounded
// outstanding fetches, bus errors for out-of-range addresses and optional stall injection.
module cv32e40x_instr_obi_mem
    import cv32e40x_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          STALL_EN        = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_req_i,
    output logic                         instr_gnt_o,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned OUT_W = 3;
    // 33-bit bounds so BASE_ADDR near the top of the map cannot wrap the limit.
    localparam logic [32:0] ADDR_LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI   = ADDR_LO + (33'(MEM_WORDS) << 2);
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic             in_range;
    logic             stall_gnt;
    logic             stall_rvalid;
    logic [OUT_W-1:0] outstanding;
    logic             p_valid;
    logic             p_err;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    obi_inst_resp_t   fifo_in;
    obi_inst_resp_t   fifo_head;

    assign in_range = ({1'b0, instr_addr_i} >= ADDR_LO) && ({1'b0, instr_addr_i} < ADDR_HI);

    // A response popped this cycle frees its credit for a same-cycle grant.
    assign instr_gnt_o = instr_req_i && !stall_gnt &&
                         ((outstanding < OUT_W'(MAX_OUTSTANDING)) || instr_rvalid_o);
    assign mem_req_o   = instr_gnt_o && in_range;
    assign mem_addr_o  = AW'((instr_addr_i - BASE_ADDR) >> 2);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding <= '0;
            p_valid     <= 1'b0;
            p_err       <= 1'b0;
        end else begin
            p_valid <= instr_gnt_o;
            p_err   <= !in_range;
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign fifo_push     = p_valid;
    assign fifo_in.rdata = p_err ? 32'h0 : mem_rdata_i;
    assign fifo_in.err   = p_err;
    assign fifo_pop      = instr_rvalid_o;

    cv32e40x_instr_mem_resp_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .elem_t (obi_inst_resp_t)
    ) u_resp_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign instr_rvalid_o = !fifo_empty && !stall_rvalid;
    assign instr_rdata_o  = instr_rvalid_o ? fifo_head.rdata : 32'h0;
    assign instr_err_o    = instr_rvalid_o ? fifo_head.err : 1'b0;

    generate
        if (STALL_EN) begin : g_lfsr
            logic [15:0] lfsr_q;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) lfsr_q <= LFSR_INIT;
                else         lfsr_q <= {^(lfsr_q & INSTR_LFSR_TAPS), lfsr_q[15:1]};
            end
            assign stall_gnt    = lfsr_q[0];
            assign stall_rvalid = lfsr_q[1];
        end else begin : g_no_lfsr
            assign stall_gnt    = 1'b0;
            assign stall_rvalid = 1'b0;
        end
    endgenerate

    // The credit counter covers pending and queued entries, so the FIFO cannot overflow.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_full && fifo_push && !fifo_pop));

endmodule

// File: tb/tb_cv32e40x_instr_obi_mem.sv
// Directed bench for the instruction OBI memory bridge: four instances cover
// back-to-back hits, bus errors, a single credit, stall injection and mid-flight reset.
module tb_cv32e40x_instr_obi_mem;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // A: base 0, 64 words, 2 credits. B: base 0x1000, 16 words. C: 1 credit. D: stalls on.
    logic a_req, a_gnt, a_rvalid, a_err, a_mreq;
    logic b_req, b_gnt, b_rvalid, b_err, b_mreq;
    logic c_req, c_gnt, c_rvalid, c_err, c_mreq;
    logic d_req, d_gnt, d_rvalid, d_err, d_mreq;
    logic [31:0] a_addr, a_rdata, a_mrdata;
    logic [31:0] b_addr, b_rdata, b_mrdata;
    logic [31:0] c_addr, c_rdata, c_mrdata;
    logic [31:0] d_addr, d_rdata, d_mrdata;
    logic [5:0]  a_maddr, c_maddr, d_maddr;
    logic [3:0]  b_maddr;

    function automatic logic [31:0] sram_word(input logic [31:0] idx);
        if (idx == 32'd0) return 32'h0000_0013;
        if (idx == 32'd1) return 32'h0010_0093;
        return 32'h1000_0000 + idx * 32'h0001_0003;
    endfunction

    always_ff @(posedge clk) if (a_mreq) a_mrdata <= sram_word({26'b0, a_maddr});
    always_ff @(posedge clk) if (b_mreq) b_mrdata <= sram_word({28'b0, b_maddr});
    always_ff @(posedge clk) if (c_mreq) c_mrdata <= sram_word({26'b0, c_maddr});
    always_ff @(posedge clk) if (d_mreq) d_mrdata <= sram_word({26'b0, d_maddr});

    cv32e40x_instr_obi_mem #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .MAX_OUTSTANDING(2),
                             .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(a_req), .instr_gnt_o(a_gnt),
        .instr_addr_i(a_addr), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
        .instr_err_o(a_err), .mem_req_o(a_mreq), .mem_addr_o(a_maddr), .mem_rdata_i(a_mrdata));

    cv32e40x_instr_obi_mem #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .MAX_OUTSTANDING(2),
                             .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(b_req), .instr_gnt_o(b_gnt),
        .instr_addr_i(b_addr), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
        .instr_err_o(b_err), .mem_req_o(b_mreq), .mem_addr_o(b_maddr), .mem_rdata_i(b_mrdata));

    cv32e40x_instr_obi_mem #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .MAX_OUTSTANDING(1),
                             .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(c_req), .instr_gnt_o(c_gnt),
        .instr_addr_i(c_addr), .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata),
        .instr_err_o(c_err), .mem_req_o(c_mreq), .mem_addr_o(c_maddr), .mem_rdata_i(c_mrdata));

    cv32e40x_instr_obi_mem #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .MAX_OUTSTANDING(2),
                             .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(d_req), .instr_gnt_o(d_gnt),
        .instr_addr_i(d_addr), .instr_rvalid_o(d_rvalid), .instr_rdata_o(d_rdata),
        .instr_err_o(d_err), .mem_req_o(d_mreq), .mem_addr_o(d_maddr), .mem_rdata_i(d_mrdata));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [5:0]  c_eg;
    logic [5:0]  c_erv;
    logic [31:0] c_ad   [6];
    logic [31:0] c_data [6];
    logic [31:0] q [$];
    int          issued;
    int          got;
    int          d_out;
    logic        g_s;
    logic        rv_s;

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0; d_req = 1'b0;
        a_addr = '0;  b_addr = '0;  c_addr = '0;  d_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        sample();
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chk32("rst_a_rdata", a_rdata, 32'h0);
        chk1("rst_a_err", a_err, 1'b0);
        chk1("rst_a_mreq", a_mreq, 1'b0);
        chk1("rst_b_rvalid", b_rvalid, 1'b0);
        chk1("rst_c_rvalid", c_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        next_cyc();

        // back-to-back hits
        a_req = 1'b1; a_addr = 32'h0;
        sample();
        chk1("b2b_gnt0", a_gnt, 1'b1);
        chk1("b2b_mreq0", a_mreq, 1'b1);
        chk32("b2b_maddr0", {26'b0, a_maddr}, 32'd0);
        next_cyc();
        a_addr = 32'h4;
        sample();
        chk1("b2b_gnt1", a_gnt, 1'b1);
        chk32("b2b_maddr1", {26'b0, a_maddr}, 32'd1);
        chk1("b2b_rv_c1", a_rvalid, 1'b0);
        next_cyc();
        a_req = 1'b0;
        sample();
        chk1("b2b_rv_c2", a_rvalid, 1'b1);
        chk32("b2b_data_c2", a_rdata, 32'h0000_0013);
        chk1("b2b_err_c2", a_err, 1'b0);
        next_cyc();
        sample();
        chk1("b2b_rv_c3", a_rvalid, 1'b1);
        chk32("b2b_data_c3", a_rdata, 32'h0010_0093);
        next_cyc();
        sample();
        chk1("b2b_rv_c4", a_rvalid, 1'b0);
        chk32("b2b_idle_data", a_rdata, 32'h0);
        next_cyc();

        // pop-credit grant
        a_req = 1'b1; a_addr = 32'h8;
        sample();
        chk1("pc_gnt0", a_gnt, 1'b1);
        next_cyc();
        a_addr = 32'hC;
        sample();
        chk1("pc_gnt1", a_gnt, 1'b1);
        next_cyc();
        a_addr = 32'h10;
        sample();
        chk32("pc_cnt_full", {29'b0, u_a.outstanding}, 32'd2);
        chk1("pc_rv_c2", a_rvalid, 1'b1);
        chk32("pc_data_c2", a_rdata, 32'h1002_0006);
        chk1("pc_gnt_on_pop", a_gnt, 1'b1);
        next_cyc();
        a_req = 1'b0;
        sample();
        chk32("pc_cnt_after", {29'b0, u_a.outstanding}, 32'd2);
        chk1("pc_rv_c3", a_rvalid, 1'b1);
        chk32("pc_data_c3", a_rdata, 32'h1003_0009);
        next_cyc();
        sample();
        chk32("pc_data_c4", a_rdata, 32'h1004_000C);
        next_cyc();
        sample();
        chk1("pc_rv_c5", a_rvalid, 1'b0);
        chk32("pc_cnt_idle", {29'b0, u_a.outstanding}, 32'd0);
        next_cyc();

        // error responses below, above and just inside the window
        b_req = 1'b1; b_addr = 32'h0000_0FFC;
        sample();
        chk1("err_lo_gnt", b_gnt, 1'b1);
        chk1("err_lo_mreq", b_mreq, 1'b0);
        next_cyc();
        b_req = 1'b0;
        next_cyc();
        sample();
        chk1("err_lo_rv", b_rvalid, 1'b1);
        chk1("err_lo_err", b_err, 1'b1);
        chk32("err_lo_data", b_rdata, 32'h0);
        next_cyc();
        b_req = 1'b1; b_addr = 32'h0000_1040;
        sample();
        chk1("err_hi_gnt", b_gnt, 1'b1);
        chk1("err_hi_mreq", b_mreq, 1'b0);
        next_cyc();
        b_req = 1'b0;
        sample();
        chk1("err_hi_rv_c1", b_rvalid, 1'b0);
        next_cyc();
        sample();
        chk1("err_hi_rv", b_rvalid, 1'b1);
        chk1("err_hi_err", b_err, 1'b1);
        chk32("err_hi_data", b_rdata, 32'h0);
        next_cyc();
        b_req = 1'b1; b_addr = 32'h0000_103C;
        sample();
        chk1("last_gnt", b_gnt, 1'b1);
        chk1("last_mreq", b_mreq, 1'b1);
        chk32("last_maddr", {28'b0, b_maddr}, 32'd15);
        next_cyc();
        b_req = 1'b0;
        next_cyc();
        sample();
        chk1("last_rv", b_rvalid, 1'b1);
        chk1("last_err", b_err, 1'b0);
        chk32("last_data", b_rdata, 32'h100F_002D);
        next_cyc();
        sample();
        chk1("last_rv_done", b_rvalid, 1'b0);
        next_cyc();

        // credit limit with one outstanding
        c_eg   = 6'b010101;
        c_erv  = 6'b010100;
        c_ad   = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
        c_data = '{32'h0, 32'h0, 32'h0000_0013, 32'h0, 32'h0010_0093, 32'h0};
        for (int i = 0; i < 6; i++) begin
            c_req = 1'b1; c_addr = c_ad[i];
            sample();
            chk1($sformatf("cl_gnt_c%0d", i), c_gnt, c_eg[i]);
            chk1($sformatf("cl_rv_c%0d", i), c_rvalid, c_erv[i]);
            chk32($sformatf("cl_data_c%0d", i), c_rdata, c_data[i]);
            next_cyc();
        end
        c_req = 1'b0;
        sample();
        chk1("cl_rv_c6", c_rvalid, 1'b1);
        chk32("cl_data_c6", c_rdata, 32'h1002_0006);
        next_cyc();
        sample();
        chk1("cl_rv_c7", c_rvalid, 1'b0);
        next_cyc();

        // stall injection: 200 random fetches tracked by an in-order scoreboard
        issued = 0; got = 0; d_out = 0;
        for (int cyc = 0; cyc < 6000 && got < 200; cyc++) begin
            if (!d_req && issued < 200 && $urandom_range(0, 3) != 0) begin
                d_req  = 1'b1;
                d_addr = 32'($urandom_range(0, 63)) << 2;
            end
            sample();
            g_s  = d_gnt;
            rv_s = d_rvalid;
            if (rv_s) begin
                chk1("st_no_extra_resp", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    chk32("st_data", d_rdata, sram_word(q[0]));
                    chk1("st_err", d_err, 1'b0);
                    void'(q.pop_front());
                end
                got++;
            end else begin
                chk32("st_idle_data", {d_rdata[31:1], d_rdata[0] | d_err}, 32'h0);
            end
            if (g_s) begin
                chk1("st_credit", (d_out < 2) || rv_s, 1'b1);
                q.push_back(d_addr >> 2);
                issued++;
            end
            d_out = d_out + (g_s ? 1 : 0) - (rv_s ? 1 : 0);
            next_cyc();
            if (g_s) d_req = 1'b0;
        end
        d_req = 1'b0;
        chk32("st_resp_count", 32'(got), 32'd200);
        chk32("st_leftover", 32'(q.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk1("st_no_dup", d_rvalid, 1'b0);
            next_cyc();
        end

        // mid-flight reset
        a_req = 1'b1; a_addr = 32'h0;
        sample();
        chk1("mr_gnt0", a_gnt, 1'b1);
        next_cyc();
        a_addr = 32'h4; rst_n = 1'b0;
        next_cyc();
        a_req = 1'b0; rst_n = 1'b1;
        sample();
        chk32("mr_cnt", {29'b0, u_a.outstanding}, 32'd0);
        chk1("mr_rv_c2", a_rvalid, 1'b0);
        next_cyc();
        sample();
        chk1("mr_rv_c3", a_rvalid, 1'b0);
        next_cyc();
        sample();
        chk1("mr_rv_c4", a_rvalid, 1'b0);
        next_cyc();
        a_req = 1'b1; a_addr = 32'h8;
        sample();
        chk1("mr_new_gnt", a_gnt, 1'b1);
        chk32("mr_new_maddr", {26'b0, a_maddr}, 32'd2);
        next_cyc();
        a_req = 1'b0;
        sample();
        chk1("mr_new_rv_c1", a_rvalid, 1'b0);
        next_cyc();
        sample();
        chk1("mr_new_rv", a_rvalid, 1'b1);
        chk32("mr_new_data", a_rdata, 32'h1002_0006);
        chk1("mr_new_err", a_err, 1'b0);
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
